// File: rtl/prefix_subtractor_pipe_pkg.sv
// Shared types and constants for the pipelined prefix-tree subtractor.
package prefix_sub_pkg;

  localparam int STAGES = 3;

  typedef logic [STAGES-1:0] stage_valid_t;

  typedef struct packed {
    logic p;
    logic g;
  } pg_t;

  function automatic int levels(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/prefix_subtractor_pipe_if.sv
// Operand/result stream interface for prefix_subtractor_pipe.
// Defining PREFIX_SUB_FLAGS_EN adds the zero/negative/overflow result flags.
interface prefix_subtractor_pipe_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] minuend;
  logic [WIDTH-1:0] subtrahend;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;

`ifdef PREFIX_SUB_FLAGS_EN
  logic             zero;
  logic             negative;
  logic             overflow;

  modport master (
    output in_valid, minuend, subtrahend, bin, out_ready,
    input  in_ready, out_valid, diff, bout, zero, negative, overflow
  );

  modport slave (
    input  in_valid, minuend, subtrahend, bin, out_ready,
    output in_ready, out_valid, diff, bout, zero, negative, overflow
  );
`else
  modport master (
    output in_valid, minuend, subtrahend, bin, out_ready,
    input  in_ready, out_valid, diff, bout
  );

  modport slave (
    input  in_valid, minuend, subtrahend, bin, out_ready,
    output in_ready, out_valid, diff, bout
  );
`endif

endinterface

// File: rtl/prefix_subtractor_pipe_pg_combine.sv
// One prefix-tree node: merges a high (p,g) span with the adjacent lower span.
module pg_combine
  import prefix_sub_pkg::*;
(
  input  pg_t hi,
  input  pg_t lo,
  output pg_t o
);

  assign o.p = hi.p & lo.p;
  assign o.g = hi.g | (hi.p & lo.g);

endmodule

// File: rtl/prefix_subtractor_pipe.sv
// Pipelined prefix-tree subtractor (A - B - bin) with an elastic 3-stage valid/ready pipeline.
// Define PREFIX_SUB_FLAGS_EN to add registered zero/negative/overflow outputs.
module prefix_subtractor_pipe
  import prefix_sub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic                     clk,
  input logic                     rst_n,
  prefix_subtractor_pipe_if.slave bus
);

  localparam int L  = levels(WIDTH);
  localparam int LH = L / 2;
  localparam int LU = L - LH;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] nb;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic             c0;
  } stage_data_t;

  stage_valid_t     vld;
  stage_valid_t     rdy;
  stage_data_t      s0_d, s0_q, s1_d, s1_q;
  logic [WIDTH-1:0] lo_p, lo_g, hi_p, hi_g;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] diff_d, diff_q;
  logic             bout_d, bout_q;
`ifdef PREFIX_SUB_FLAGS_EN
  logic             zero_d, neg_d, ovf_d;
  logic             zero_q, neg_q, ovf_q;
`endif

  // A stage may load when it is empty or its contents move on this cycle.
  assign rdy[2] = ~vld[2] | bus.out_ready;
  assign rdy[1] = ~vld[1] | rdy[2];
  assign rdy[0] = ~vld[0] | rdy[1];

  // Subtraction is A + ~B + ~bin, so the prefix network sees ~B and carry-in ~bin.
  always_comb begin
    s0_d    = '0;
    s0_d.a  = bus.minuend;
    s0_d.nb = ~bus.subtrahend;
    s0_d.p  = bus.minuend | ~bus.subtrahend;
    s0_d.g  = bus.minuend & ~bus.subtrahend;
    s0_d.c0 = ~bus.bin;
  end

  for (genvar l = 0; l < LH; l++) begin : g_lo
    localparam int SPAN = 1 << l;
    for (genvar i = 0; i < WIDTH; i++) begin : g_node
      pg_t hi_in;
      pg_t res;
      if (l == 0) begin : g_src
        assign hi_in = '{p: s0_q.p[i], g: s0_q.g[i]};
      end else begin : g_src
        assign hi_in = g_lo[l-1].g_node[i].res;
      end
      if (i < SPAN) begin : g_op
        assign res = hi_in;
      end else begin : g_op
        pg_t lo_in;
        if (l == 0) begin : g_lsrc
          assign lo_in = '{p: s0_q.p[i-SPAN], g: s0_q.g[i-SPAN]};
        end else begin : g_lsrc
          assign lo_in = g_lo[l-1].g_node[i-SPAN].res;
        end
        pg_combine u_pg (.hi(hi_in), .lo(lo_in), .o(res));
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_lo_out
    assign lo_p[i] = g_lo[LH-1].g_node[i].res.p;
    assign lo_g[i] = g_lo[LH-1].g_node[i].res.g;
  end

  assign s1_d = '{a: s0_q.a, nb: s0_q.nb, p: lo_p, g: lo_g, c0: s0_q.c0};

  for (genvar j = 0; j < LU; j++) begin : g_hi
    localparam int SPAN = 1 << (LH + j);
    for (genvar i = 0; i < WIDTH; i++) begin : g_node
      pg_t hi_in;
      pg_t res;
      if (j == 0) begin : g_src
        assign hi_in = '{p: s1_q.p[i], g: s1_q.g[i]};
      end else begin : g_src
        assign hi_in = g_hi[j-1].g_node[i].res;
      end
      if (i < SPAN) begin : g_op
        assign res = hi_in;
      end else begin : g_op
        pg_t lo_in;
        if (j == 0) begin : g_lsrc
          assign lo_in = '{p: s1_q.p[i-SPAN], g: s1_q.g[i-SPAN]};
        end else begin : g_lsrc
          assign lo_in = g_hi[j-1].g_node[i-SPAN].res;
        end
        pg_combine u_pg (.hi(hi_in), .lo(lo_in), .o(res));
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_hi_out
    assign hi_p[i] = g_hi[LU-1].g_node[i].res.p;
    assign hi_g[i] = g_hi[LU-1].g_node[i].res.g;
  end

  // Group (P,G) over bits [i:0] folds in the carry-in to give the carry into bit i+1.
  always_comb begin
    carry  = {hi_g | (hi_p & {WIDTH{s1_q.c0}}), s1_q.c0};
    diff_d = s1_q.a ^ s1_q.nb ^ carry[WIDTH-1:0];
    bout_d = ~carry[WIDTH];
`ifdef PREFIX_SUB_FLAGS_EN
    zero_d = (diff_d == '0);
    neg_d  = diff_d[WIDTH-1];
    ovf_d  = (s1_q.a[WIDTH-1] == s1_q.nb[WIDTH-1]) && (diff_d[WIDTH-1] != s1_q.a[WIDTH-1]);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld    <= '0;
      s0_q   <= '0;
      s1_q   <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
`ifdef PREFIX_SUB_FLAGS_EN
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      ovf_q  <= 1'b0;
`endif
    end else begin
      if (rdy[0]) vld[0] <= bus.in_valid;
      if (rdy[1]) vld[1] <= vld[0];
      if (rdy[2]) vld[2] <= vld[1];
      // Data only moves with a real beat so undriven operands never propagate.
      if (rdy[0] && bus.in_valid) s0_q <= s0_d;
      if (rdy[1] && vld[0])       s1_q <= s1_d;
      if (rdy[2] && vld[1]) begin
        diff_q <= diff_d;
        bout_q <= bout_d;
`ifdef PREFIX_SUB_FLAGS_EN
        zero_q <= zero_d;
        neg_q  <= neg_d;
        ovf_q  <= ovf_d;
`endif
      end
    end
  end

  assign bus.in_ready  = rdy[0];
  assign bus.out_valid = vld[2];
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;
`ifdef PREFIX_SUB_FLAGS_EN
  assign bus.zero      = zero_q;
  assign bus.negative  = neg_q;
  assign bus.overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_prefix_subtractor_pipe.sv
// Self-checking bench for prefix_subtractor_pipe: directed table, stall/reset sequences, random stream.
// Flag outputs are checked when PREFIX_SUB_FLAGS_EN is defined.
module tb_prefix_subtractor_pipe;

  localparam int W = 16;
  localparam int NVEC = 11;
  localparam int NRAND = 10000;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
    logic         zero;
    logic         negative;
    logic         overflow;
  } exp_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    exp_t         e;
  } vec_t;

  logic clk;
  logic rst_n;

  prefix_subtractor_pipe_if #(.WIDTH(W)) bus ();

  prefix_subtractor_pipe #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  int   out_count = 0;
  exp_t expq[$];

  logic         obs_in_acc, obs_out_acc, obs_out_valid, obs_in_ready;
  logic [W-1:0] obs_diff;
  logic         obs_bout, obs_zero, obs_neg, obs_ovf;

  // Reference: plain integer subtraction; flags follow their definitions directly.
  function automatic exp_t ref_model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    exp_t e;
    int   r;
    r          = int'(a) - int'(b) - int'(bin);
    e.diff     = r[W-1:0];
    e.bout     = (r < 0);
    e.zero     = (e.diff == '0);
    e.negative = e.diff[W-1];
    e.overflow = (a[W-1] != b[W-1]) && (e.diff[W-1] != a[W-1]);
    return e;
  endfunction

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return W'($urandom());
    endcase
  endfunction

  task automatic applyStimulus(input logic valid, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic bin);
    bus.in_valid = valid;
    if (valid) begin
      bus.minuend    = a;
      bus.subtrahend = b;
      bus.bin        = bin;
    end else begin
      bus.minuend    = 'x;
      bus.subtrahend = 'x;
      bus.bin        = 1'bx;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_beat(input string tag, input exp_t e);
    checkOutput({tag, "_diff"}, 32'(obs_diff), 32'(e.diff));
    checkOutput({tag, "_bout"}, 32'(obs_bout), 32'(e.bout));
`ifdef PREFIX_SUB_FLAGS_EN
    checkOutput({tag, "_zero"}, 32'(obs_zero), 32'(e.zero));
    checkOutput({tag, "_negative"}, 32'(obs_neg), 32'(e.negative));
    checkOutput({tag, "_overflow"}, 32'(obs_ovf), 32'(e.overflow));
`endif
  endtask

  // Observe handshakes at the falling edge, score them, then return just after the next rising edge.
  task automatic sample_cycle();
    exp_t e;
    @(negedge clk);
    obs_in_ready  = bus.in_ready;
    obs_out_valid = bus.out_valid;
    obs_in_acc    = bus.in_valid && bus.in_ready;
    obs_out_acc   = bus.out_valid && bus.out_ready;
    obs_diff      = bus.diff;
    obs_bout      = bus.bout;
`ifdef PREFIX_SUB_FLAGS_EN
    obs_zero      = bus.zero;
    obs_neg       = bus.negative;
    obs_ovf       = bus.overflow;
`else
    obs_zero      = 1'b0;
    obs_neg       = 1'b0;
    obs_ovf       = 1'b0;
`endif
    if (obs_out_acc) begin
      out_count++;
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL stray_beat: got diff 0x%0h, expected no beat", obs_diff);
      end else begin
        e = expq.pop_front();
        check_beat("stream", e);
      end
    end
    if (obs_in_acc) expq.push_back(ref_model(bus.minuend, bus.subtrahend, bus.bin));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b0);
    repeat (6) sample_cycle();
  endtask

  vec_t         vecs [NVEC];
  logic [W-1:0] sa [6];
  logic [W-1:0] sb [6];
  logic         sbin [6];

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   idx;
    int   waits;
    int   start;
    int   sent;
    exp_t e0;

    //                a         b         bin    diff      bout  zero  neg   ovf
    vecs[0]  = '{16'h0000, 16'h0001, 1'b0, '{16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0}};
    vecs[1]  = '{16'h1234, 16'h0234, 1'b0, '{16'h1000, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[2]  = '{16'h8000, 16'h0001, 1'b1, '{16'h7FFE, 1'b0, 1'b0, 1'b0, 1'b1}};
    vecs[3]  = '{16'h8000, 16'h0001, 1'b0, '{16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1}};
    vecs[4]  = '{16'h5A5A, 16'h5A5A, 1'b0, '{16'h0000, 1'b0, 1'b1, 1'b0, 1'b0}};
    vecs[5]  = '{16'h0000, 16'h0000, 1'b1, '{16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0}};
    vecs[6]  = '{16'hFFFF, 16'hFFFF, 1'b1, '{16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0}};
    vecs[7]  = '{16'hFFFF, 16'h0000, 1'b0, '{16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0}};
    vecs[8]  = '{16'h7FFF, 16'hFFFF, 1'b0, '{16'h8000, 1'b1, 1'b0, 1'b1, 1'b1}};
    vecs[9]  = '{16'h0001, 16'h0000, 1'b1, '{16'h0000, 1'b0, 1'b1, 1'b0, 1'b0}};
    vecs[10] = '{16'h0001, 16'h8000, 1'b0, '{16'h8001, 1'b1, 1'b0, 1'b1, 1'b1}};

    rst_n = 1'b0;
    bus.out_ready = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset_diff", 32'(bus.diff), 32'd0);
    checkOutput("reset_bout", 32'(bus.bout), 32'd0);
    checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    $display("[TB] directed table");
    bus.out_ready = 1'b1;
    for (int v = 0; v < NVEC; v++) begin
      applyStimulus(1'b1, vecs[v].a, vecs[v].b, vecs[v].bin);
      sample_cycle();
      checkOutput($sformatf("vec%0d_accept", v), 32'(obs_in_acc), 32'd1);
      applyStimulus(1'b0, '0, '0, 1'b0);
      waits = 0;
      do begin
        sample_cycle();
        waits++;
      end while (!obs_out_acc && waits < 8);
      checkOutput($sformatf("vec%0d_latency", v), 32'(waits), 32'd3);
      check_beat($sformatf("vec%0d", v), vecs[v].e);
    end

    $display("[TB] stall with full pipeline");
    drain();
    for (int i = 0; i < 6; i++) begin
      sa[i]   = rand_op();
      sb[i]   = rand_op();
      sbin[i] = 1'($urandom_range(0, 1));
    end
    e0 = ref_model(sa[0], sb[0], sbin[0]);
    bus.out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b1, sa[idx], sb[idx], sbin[idx]);
      sample_cycle();
      if (obs_in_acc) idx++;
      if (c >= 3) begin
        checkOutput($sformatf("stall_c%0d_out_valid", c), 32'(obs_out_valid), 32'd1);
        check_beat($sformatf("stall_c%0d_hold", c), e0);
      end
      if (c == 4) checkOutput("stall_in_ready", 32'(obs_in_ready), 32'd0);
    end
    checkOutput("stall_accepted", 32'(idx), 32'd3);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (idx < 6) applyStimulus(1'b1, sa[idx], sb[idx], sbin[idx]);
      else         applyStimulus(1'b0, '0, '0, 1'b0);
      sample_cycle();
      if (obs_in_acc) idx++;
      checkOutput($sformatf("release_c%0d_out", c), 32'(obs_out_acc), 32'd1);
    end
    checkOutput("release_accepted", 32'(idx), 32'd6);

    $display("[TB] reset with beats in flight");
    drain();
    bus.out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, rand_op(), rand_op(), 1'($urandom_range(0, 1)));
      sample_cycle();
      if (obs_in_acc) idx++;
    end
    checkOutput("midreset_filled", 32'(idx), 32'd3);
    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    expq.delete();
    @(negedge clk);
    checkOutput("midreset_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("midreset_diff", 32'(bus.diff), 32'd0);
    checkOutput("midreset_bout", 32'(bus.bout), 32'd0);
    checkOutput("midreset_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef PREFIX_SUB_FLAGS_EN
    checkOutput("midreset_flags", {29'd0, bus.zero, bus.negative, bus.overflow}, 32'd0);
`endif
    @(posedge clk);
    #1;
    start = out_count;
    repeat (8) sample_cycle();
    checkOutput("midreset_no_stale", 32'(out_count - start), 32'd0);

    $display("[TB] random stream");
    start = out_count;
    sent  = 0;
    for (int cyc = 0; cyc < 60000 && (out_count - start) < NRAND; cyc++) begin
      if (sent < NRAND && $urandom_range(0, 9) < 7)
        applyStimulus(1'b1, rand_op(), rand_op(), 1'($urandom_range(0, 1)));
      else
        applyStimulus(1'b0, '0, '0, 1'b0);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      sample_cycle();
      if (obs_in_acc) sent++;
    end
    checkOutput("random_beats_out", 32'(out_count - start), 32'(NRAND));
    drain();
    checkOutput("scoreboard_empty", 32'(expq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
